// File: rtl/axis_lb_pkg.sv
// Shared definitions for the loopback/local AXI-Stream TX arbiter:
// FSM state encoding, default frame length limit and the beat bundle type.
package axis_lb_pkg;

  localparam int MAX_BEATS_DEF = 512;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS0 = 2'd1;
  localparam logic [1:0] ST_PASS1 = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
  } axis_beat_t;

endpackage

// File: rtl/axis_lb_stat_cnt.sv
// Frame statistics for the TX arbiter: per-input forwarded frames, truncations
// and a slow activity indicator taken from the total forwarded-frame count.
module axis_lb_stat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc0,
  input  logic        inc1,
  input  logic        inc_trunc,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1,
  output logic [15:0] trunc_cnt,
  output logic        activity_flash
);

  logic [15:0] frm_cnt0_r;
  logic [15:0] frm_cnt1_r;
  logic [15:0] trunc_cnt_r;
  logic [15:0] total_r;

  // Free-running 16-bit counters that wrap naturally at 0xFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt0_r  <= 16'd0;
      frm_cnt1_r  <= 16'd0;
      trunc_cnt_r <= 16'd0;
      total_r     <= 16'd0;
    end else begin
      if (inc0) frm_cnt0_r <= frm_cnt0_r + 16'd1;
      if (inc1) frm_cnt1_r <= frm_cnt1_r + 16'd1;
      if (inc_trunc) trunc_cnt_r <= trunc_cnt_r + 16'd1;
      if (inc0 || inc1) total_r <= total_r + 16'd1;
    end
  end

  assign frm_cnt0       = frm_cnt0_r;
  assign frm_cnt1       = frm_cnt1_r;
  assign trunc_cnt      = trunc_cnt_r;
  assign activity_flash = total_r[13];

endmodule

// File: rtl/axis_lb_tx_arbiter.sv
// Frame-level round-robin merge of the loopback FIFO stream and the local PTP
// command stream onto the MAC TX interface, with over-length truncation.
module axis_lb_tx_arbiter
  import axis_lb_pkg::*;
#(
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic        axis_tx_clk,
  input  logic        axis_resetn,
  input  logic [1:0]  port_en,
  input  logic [31:0] s0_axis_tdata,
  input  logic [3:0]  s0_axis_tkeep,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  input  logic        s0_axis_tuser,
  output logic        s0_axis_tready,
  input  logic [31:0] s1_axis_tdata,
  input  logic [3:0]  s1_axis_tkeep,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  input  logic        s1_axis_tuser,
  output logic        s1_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1,
  output logic [15:0] trunc_cnt,
  output logic        activity_flash
);

  localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

  logic [1:0]  rst_sync_r;
  logic        rst_n_s;
  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        ptr_r;
  logic        ptr_nxt_s;
  logic        port_r;
  logic        port_nxt_s;
  logic [15:0] beat_cnt_r;
  axis_beat_t  cur_s;
  logic        sel_s;
  logic        trunc_s;
  logic        xfer_s;
  logic        pass_end_s;
  logic        drop_valid_s;
  logic        drop_last_s;
  logic        elig0_s;
  logic        elig1_s;

  // Reset asserts asynchronously, releases two clocks after axis_resetn rises.
  always_ff @(posedge axis_tx_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Select the owning input; outside PASS states everything reads as idle.
  always_comb begin
    cur_s = '0;
    case (state_r)
      ST_PASS0: cur_s = {s0_axis_tdata, s0_axis_tkeep, s0_axis_tvalid, s0_axis_tlast, s0_axis_tuser};
      ST_PASS1: cur_s = {s1_axis_tdata, s1_axis_tkeep, s1_axis_tvalid, s1_axis_tlast, s1_axis_tuser};
      default:  cur_s = '0;
    endcase
  end

  assign sel_s        = (state_r == ST_PASS1);
  assign trunc_s      = cur_s.tvalid & (beat_cnt_r == LAST_BEAT) & ~cur_s.tlast;
  assign xfer_s       = cur_s.tvalid & m_axis_tready;
  assign pass_end_s   = xfer_s & (cur_s.tlast | trunc_s);
  assign drop_valid_s = port_r ? s1_axis_tvalid : s0_axis_tvalid;
  assign drop_last_s  = port_r ? s1_axis_tlast : s0_axis_tlast;
  assign elig0_s      = s0_axis_tvalid & port_en[0];
  assign elig1_s      = s1_axis_tvalid & port_en[1];

  assign m_axis_tdata  = cur_s.tdata;
  assign m_axis_tkeep  = cur_s.tkeep;
  assign m_axis_tvalid = cur_s.tvalid;
  assign m_axis_tlast  = cur_s.tlast | trunc_s;
  assign m_axis_tuser  = cur_s.tuser | trunc_s;

  // The dropped tail of a truncated frame is drained regardless of the MAC.
  assign s0_axis_tready = ((state_r == ST_PASS0) & m_axis_tready) | ((state_r == ST_DROP) & ~port_r);
  assign s1_axis_tready = ((state_r == ST_PASS1) & m_axis_tready) | ((state_r == ST_DROP) & port_r);

  // Next-state logic; port_en only gates new grants, never an owned frame.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    port_nxt_s  = port_r;
    case (state_r)
      ST_IDLE: begin
        if (elig0_s && elig1_s) begin
          state_nxt_s = ptr_r ? ST_PASS1 : ST_PASS0;
        end else if (elig0_s) begin
          state_nxt_s = ST_PASS0;
        end else if (elig1_s) begin
          state_nxt_s = ST_PASS1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PASS0, ST_PASS1: begin
        if (pass_end_s) begin
          ptr_nxt_s = ~sel_s;
          if (trunc_s) begin
            state_nxt_s = ST_DROP;
            port_nxt_s  = sel_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DROP: begin
        if (drop_valid_s && drop_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Arbiter state and the per-frame beat counter (advances on transfers only).
  always_ff @(posedge axis_tx_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 1'b0;
      port_r     <= 1'b0;
      beat_cnt_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      port_r  <= port_nxt_s;
      if (pass_end_s) begin
        beat_cnt_r <= 16'd0;
      end else if (xfer_s) begin
        beat_cnt_r <= beat_cnt_r + 16'd1;
      end
    end
  end

  axis_lb_stat_cnt u_stat_cnt (
    .clk            (axis_tx_clk),
    .rst_n          (rst_n_s),
    .inc0           (pass_end_s & ~sel_s),
    .inc1           (pass_end_s & sel_s),
    .inc_trunc      (pass_end_s & trunc_s),
    .frm_cnt0       (frm_cnt0),
    .frm_cnt1       (frm_cnt1),
    .trunc_cnt      (trunc_cnt),
    .activity_flash (activity_flash)
  );

endmodule

// File: tb/tb_axis_lb_tx_arbiter.sv
// Scoreboard bench for axis_lb_tx_arbiter: per-input source queues feed the
// DUT, a reference model predicts the merged output stream into exp_q.
module tb_axis_lb_tx_arbiter;

  localparam int MAXB = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        axis_tx_clk = 1'b0;
  logic        axis_resetn;
  logic [1:0]  port_en;
  logic [31:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [3:0]  s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic        s0_axis_tvalid, s0_axis_tlast, s0_axis_tuser, s0_axis_tready;
  logic        s1_axis_tvalid, s1_axis_tlast, s1_axis_tuser, s1_axis_tready;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic [15:0] frm_cnt0, frm_cnt1, trunc_cnt;
  logic        activity_flash;

  beat_t src_q0[$];
  beat_t src_q1[$];
  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    en_clr_at = -1;
  logic  bp_mode = 1'b0;
  int    cyc_s;

  axis_lb_tx_arbiter #(.MAX_BEATS(MAXB)) dut (
    .axis_tx_clk(axis_tx_clk), .axis_resetn(axis_resetn), .port_en(port_en),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1), .trunc_cnt(trunc_cnt),
    .activity_flash(activity_flash)
  );

  initial forever #5 axis_tx_clk = ~axis_tx_clk;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Queue one input frame and the output the arbiter must produce for it.
  task automatic add_frame(input int port, input int fid, input int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data = {4'(port), 12'(fid), 16'(i)};
      b.keep = (i == nb - 1) ? 4'h7 : 4'hF;
      b.last = (i == nb - 1);
      b.user = ((i % 5) == 2);
      if (port == 0) src_q0.push_back(b); else src_q1.push_back(b);
      if (i < MAXB) begin
        if (i == MAXB - 1 && !b.last) begin
          b.last = 1'b1;
          b.user = 1'b1;
        end
        exp_q.push_back(b);
      end
    end
  endtask

  // One clock: drive source heads, monitor output, retire accepted beats.
  task automatic step(input int cyc);
    beat_t b0, b1, eb;
    logic  hs0, hs1;
    @(negedge axis_tx_clk);
    b0 = (src_q0.size() > 0) ? src_q0[0] : '0;
    b1 = (src_q1.size() > 0) ? src_q1[0] : '0;
    s0_axis_tvalid = (src_q0.size() > 0);
    s1_axis_tvalid = (src_q1.size() > 0);
    {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast, s0_axis_tuser} = b0;
    {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast, s1_axis_tuser} = b1;
    m_axis_tready = bp_mode ? ((cyc % 2) == 0) : 1'b1;
    if (cyc == en_clr_at) port_en[0] = 1'b0;
    #1;
    hs0 = s0_axis_tvalid && s0_axis_tready;
    hs1 = s1_axis_tvalid && s1_axis_tready;
    if (m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        chk_val("extra_beat", {26'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 64'd0);
      end else if (m_axis_tready) begin
        eb = exp_q.pop_front();
        chk_val("beat", {26'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, {26'd0, eb});
      end else begin
        chk_val("stall_hold", {26'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, {26'd0, exp_q[0]});
      end
    end
    @(posedge axis_tx_clk);
    if (hs0) void'(src_q0.pop_front());
    if (hs1) void'(src_q1.pop_front());
  endtask

  task automatic run_drain(input int budget, output int cycles);
    cycles = 0;
    while ((src_q0.size() + src_q1.size() + exp_q.size()) != 0 && cycles < budget) begin
      step(cycles);
      cycles++;
    end
    chk_val("drain_left", 64'(src_q0.size() + src_q1.size() + exp_q.size()), 64'd0);
    #2;
  endtask

  task automatic chk_cnt(input string tag, input int c0, input int c1, input int tr, input logic fl);
    chk_val({tag, "_frm0"}, 64'(frm_cnt0), 64'(c0));
    chk_val({tag, "_frm1"}, 64'(frm_cnt1), 64'(c1));
    chk_val({tag, "_trunc"}, 64'(trunc_cnt), 64'(tr));
    chk_val({tag, "_flash"}, 64'(activity_flash), 64'(fl));
  endtask

  initial begin
    port_en = 2'b11;
    {s0_axis_tdata, s0_axis_tkeep, s0_axis_tvalid, s0_axis_tlast, s0_axis_tuser} = '0;
    {s1_axis_tdata, s1_axis_tkeep, s1_axis_tvalid, s1_axis_tlast, s1_axis_tuser} = '0;
    m_axis_tready = 1'b1;
    axis_resetn = 1'b1;
    #2 axis_resetn = 1'b0;
    #1;
    chk_val("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk_val("rst_s_tready", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
    chk_cnt("rst", 0, 0, 0, 1'b0);
    repeat (2) @(negedge axis_tx_clk);
    axis_resetn = 1'b1;
    repeat (4) @(negedge axis_tx_clk);

    // Contention from reset pointer: s0, s1, s0, s1 with one bubble per frame.
    add_frame(0, 1, 4); add_frame(1, 1, 4); add_frame(0, 2, 4); add_frame(1, 2, 4);
    run_drain(200, cyc_s);
    chk_val("contend_cycles", 64'(cyc_s), 64'd20);
    chk_cnt("contend", 2, 2, 0, 1'b0);

    // Single 16-beat frame: tlast exactly at the limit is a normal end.
    add_frame(0, 3, 16);
    run_drain(200, cyc_s);
    chk_val("single_cycles", 64'(cyc_s), 64'd17);
    chk_cnt("single", 3, 2, 0, 1'b0);

    // Over-length s1 frame: 16 out with forced tlast/tuser, 4 dropped.
    add_frame(1, 4, 20);
    run_drain(200, cyc_s);
    chk_cnt("trunc", 3, 3, 1, 1'b0);
    add_frame(0, 5, 2); add_frame(1, 5, 2);
    run_drain(200, cyc_s);
    chk_cnt("post_trunc", 4, 4, 1, 1'b0);

    // Backpressure 1010 on an over-length s0 frame.
    bp_mode = 1'b1;
    add_frame(0, 6, 18);
    run_drain(400, cyc_s);
    bp_mode = 1'b0;
    chk_cnt("bp", 5, 4, 2, 1'b0);

    // Disable s0 mid-frame: frame completes, no new s0 grant.
    en_clr_at = 3;
    add_frame(0, 7, 6);
    run_drain(200, cyc_s);
    en_clr_at = -1;
    chk_cnt("en_clr", 6, 4, 2, 1'b0);
    for (int i = 0; i < 3; i++) src_q0.push_back(beat_t'({4'h0, 12'd8, 16'(i), 4'hF, 1'b0, 1'b0}));
    for (int i = 0; i < 10; i++) step(i);
    chk_val("blocked_s0", 64'(src_q0.size()), 64'd3);
    src_q0.delete();
    @(negedge axis_tx_clk);
    s0_axis_tvalid = 1'b0;
    port_en = 2'b11;

    // Reset mid-frame: outputs and counters clear immediately.
    add_frame(0, 9, 8);
    for (int i = 0; i < 3; i++) step(i);
    #2 axis_resetn = 1'b0;
    #1;
    chk_val("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk_val("midrst_s_tready", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
    chk_cnt("midrst", 0, 0, 0, 1'b0);
    src_q0.delete(); src_q1.delete(); exp_q.delete();
    @(negedge axis_tx_clk);
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    @(negedge axis_tx_clk);
    axis_resetn = 1'b1;
    repeat (4) @(negedge axis_tx_clk);

    // activity_flash follows bit 13 of the total frame count.
    for (int i = 0; i < 8191; i++) add_frame(0, i, 1);
    run_drain(20000, cyc_s);
    chk_cnt("wrap_8191", 8191, 0, 0, 1'b0);
    add_frame(0, 8191, 1);
    run_drain(20, cyc_s);
    chk_cnt("wrap_8192", 8192, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_lb_tx_arbiter.md
AXIS_LB_TX_ARBITER -- requirements
Module: axis_lb_tx_arbiter

Interface
REQ-001 Parameter MAX_BEATS, default 512, is the maximum number of 32-bit beats per frame before forced truncation; legal range 2..65535.
REQ-002 Ports:
- axis_tx_clk  in  1  sole clock.
- axis_resetn  in  1  asynchronous active-low reset.
- port_en  in  2  per-input grant enable; bit0 = loopback input, bit1 = local input.
- s0_axis_tdata / tkeep / tvalid / tlast / tuser  in  32/4/1/1/1  loopback-FIFO frame input.
- s0_axis_tready  out  1
- s1_axis_tdata / tkeep / tvalid / tlast / tuser  in  32/4/1/1/1  local (PTP command) frame input.
- s1_axis_tready  out  1
- m_axis_tdata / tkeep / tvalid / tlast / tuser  out  32/4/1/1/1  merged MAC TX output.
- m_axis_tready  in  1
- frm_cnt0, frm_cnt1  out  16  frames forwarded per input.
- trunc_cnt  out  16  frames truncated.
- activity_flash  out  1  bit 13 of the total forwarded-frame count.

Function
REQ-003 Arbitration is frame-level: once granted, an input owns the output until its tlast beat completes.
REQ-004 FSM states: IDLE, PASS0, PASS1, DROP.
REQ-005 IDLE transitions:
- Go to PASSn on the next edge when sn_axis_tvalid=1 and port_en[n]=1.
- If both inputs are eligible, grant the input indicated by the round-robin pointer.
REQ-006 Round-robin pointer:
- Reset value 0.
- After each frame end, or truncation, on port n, the pointer points to the other port.
REQ-007 In IDLE: both s*_tready=0 and m_axis_tvalid=0; the arbitration bubble is exactly one cycle.
REQ-008 In PASSn, the output is a combinational pass-through of input n:
- m_axis_t* = sn_axis_t*.
- sn_axis_tready = m_axis_tready.
- The other input's tready=0.
REQ-009 A beat transfers when m_axis_tvalid and m_axis_tready are both 1. The beat counter is 16 bits, increments per transferred beat, and clears on frame end.
REQ-010 PASSn to IDLE: on transfer of a beat with tlast=1. On the same edge, frm_cntn increments and the pointer updates.
REQ-011 Truncation: in PASSn, when the beat counter equals MAX_BEATS-1 and the current input beat has tlast=0:
- That beat is output with m_axis_tlast=1 and m_axis_tuser=1.
- On its transfer, trunc_cnt increments, frm_cntn increments, and the FSM goes to DROP with the port remembered.
REQ-012 DROP state:
- sn_axis_tready=1, m_axis_tvalid=0, input beats discarded.
- On a discarded beat with tlast=1, go to IDLE.
REQ-013 A tlast=1 beat arriving exactly at beat MAX_BEATS-1 is a normal frame end, not a truncation.
REQ-014 Clearing port_en[n] during PASSn or DROP does not abort the frame; it only blocks future grants.
REQ-015 tuser is passed through unmodified except as specified in REQ-011.
REQ-016 Counters:
- All 16-bit, wrap from 0xFFFF to 0x0000.
- activity_flash = bit 13 of an internal 16-bit total counter, which increments on every frm_cnt0 or frm_cnt1 increment.
REQ-017 The block holds no data storage, so throughput in PASS is one beat per cycle with zero added latency.

Reset
REQ-018 Asserting axis_resetn=0 asynchronously forces the following, with every output reaching its reset value within the assertion:
- FSM to IDLE, pointer to 0, beat counter to 0.
- All counters and activity_flash to 0.
- Both s*_tready=0 and m_axis_tvalid=0.
REQ-019 Reset asserted mid-frame abandons the frame. After release, the first grant restarts at the next beat presented; no cleanup of a partial input frame is performed.
REQ-020 Reset release is synchronised to axis_tx_clk with a 2-flop deassertion synchroniser.

Structure
REQ-021 The FSM state encoding and the default MAX_BEATS constant reside in a shared package, axis_lb_pkg.
REQ-022 Structure is a single module; no sub-modules are required. The counter bank may optionally be split into axis_lb_stat_cnt.

Verification
REQ-023 Single frame:
- Stimulus: s0 sends a 16-beat frame, port_en=2'b11, m_tready=1.
- Response: 16 output beats one cycle after first tvalid, frm_cnt0=1, activity_flash=0.
REQ-024 Contention:
- Stimulus: s0 and s1 both hold 4-beat frames continuously.
- Response: output order s0, s1, s0, s1; one idle cycle between frames; frm_cnt0=frm_cnt1=2 after four frames.
REQ-025 Truncation:
- Stimulus: MAX_BEATS=8, s1 sends 12 beats.
- Response: 8 beats out, beat 8 with tlast=1 and tuser=1; 4 beats dropped with s1_tready=1; trunc_cnt=1; next grant goes to s0.
REQ-026 Backpressure:
- Stimulus: m_tready toggles 1010 during a frame.
- Response: data unchanged while stalled, no beat lost or duplicated, beat counter advances only on transfers.
REQ-027 Enable and reset:
- Stimulus: clear port_en[0] mid-frame on s0.
- Response: the frame completes; no further s0 grant.
- Stimulus: assert reset mid-frame.
- Response: m_tvalid=0 and all counters 0 immediately.
REQ-028 Wrap:
- Stimulus: 8192 s0 frames.
- Response: activity_flash rises at frame 8192; frm_cnt0 wraps 0xFFFF to 0x0000 at frame 65536.
